io_bridge_n: RTL and testbench
==============================

Name: io_bridge_n

Overview:
- Parametrised successor to the CPU-to-peripheral system bridge.
- Decodes CPU I/O accesses onto NUM_DEV memory-mapped device windows.
- Adds a stall/ack handshake, a per-access timeout, bus-error reporting for unmapped or misaligned addresses, and synchronised device interrupts.
- Sits between the pipeline's memory stage and the timer/IO devices; drives HWInt into CP0.

Parameters:
- NUM_DEV, 2, number of device windows (1..5).
- BASE_ADDR, 32'h0000_7F00, byte address of window 0.
- STRIDE, 32'h10, byte spacing between window bases.
- WIN_BYTES, 12, valid bytes per window (word registers at offsets 0, 4, 8).
- TIMEOUT, 16, maximum WAIT cycles before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pr_addr  in  32  CPU byte address.
- pr_re  in  1  CPU read request; held while pr_stall=1.
- pr_we  in  1  CPU write request; held while pr_stall=1.
- pr_wd  in  32  CPU write data.
- pr_rd  out  32  read data; valid in DONE.
- pr_stall  out  1  freeze pipeline.
- pr_err  out  1  bus-error pulse in DONE.
- hw_int  out  6  interrupt vector to CP0.
- dev_addr  out  32  latched access address.
- dev_wd  out  32  latched write data.
- dev_sel  out  NUM_DEV  one-hot device request.
- dev_we  out  NUM_DEV  one-hot write strobe.
- dev_rd  in  32*NUM_DEV  device read data; slice i = [32*i+31:32*i].
- dev_ack  in  NUM_DEV  device completion.
- dev_irq  in  NUM_DEV  level interrupts, asynchronous to clk.
- ext_int  in  1  external interrupt line, asynchronous.

Behaviour:
- Decode (combinational on pr_addr):
  - hit[i] = BASE_ADDR+i*STRIDE <= pr_addr <= BASE_ADDR+i*STRIDE+WIN_BYTES-1, compared at 32 bits.
  - valid = |hit && pr_addr[1:0]==0.
  - pr_re and pr_we both high is treated as a write.
- FSM states: IDLE, WAIT, DONE. Encoding lives in the package.
- IDLE:
  - req = pr_re|pr_we. If req, pr_stall=1 combinationally.
  - req && valid: latch addr, wd, we and one-hot sel; clear timeout counter; go to WAIT.
  - req && !valid: set err_q=1, rd_q=0; go to DONE. No device sees dev_sel.
- WAIT:
  - dev_sel = sel_q; dev_we = sel_q & {NUM_DEV{we_q}}; pr_stall=1.
  - dev_ack[k] with sel_q[k]=1: rd_q = dev_rd slice k (write: rd_q=0); err_q=0; go to DONE.
  - Acks from unselected devices are ignored.
  - Otherwise cnt++. If TIMEOUT!=0 and cnt==TIMEOUT-1 with no ack: err_q=1, rd_q=0, go to DONE. An ack in that same cycle wins over the timeout.
- DONE:
  - pr_stall=0; pr_rd=rd_q; pr_err=err_q; dev_sel and dev_we are 0.
  - Always returns to IDLE. Requests present in DONE are ignored, because the CPU advances at the end of DONE.
- Latency: minimum access is request cycle + 1 WAIT + DONE (device acks in the first WAIT cycle). Error path is request cycle + DONE.
- pr_rd holds rd_q outside DONE; pr_err=0 outside DONE.
- Interrupts:
  - Each dev_irq[i] and ext_int passes through a 2-flop synchroniser, then a registered output stage.
  - hw_int[i] = irq_s[i] for i<NUM_DEV; hw_int[NUM_DEV] = ext_s; remaining bits 0.
  - Assertion latency to hw_int is 3 clk edges.
  - Interrupts are independent of FSM state and are not masked here; masking belongs to CP0.
- Reset:
  - Asynchronous. state=IDLE; all flops 0; pr_rd=0, pr_err=0, pr_stall=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wd=0, hw_int=0.
  - Reset during WAIT aborts the access immediately; no write completes afterwards.
- Elaboration check: NUM_DEV outside 1..5 is a fatal error.

Decomposition:
- Shared package io_bus_pkg holds the FSM state encoding, default BASE_ADDR, STRIDE and WIN_BYTES constants, and the HWInt width (6).
- One sub-module: io_irq_sync, a parametrised N-bit 2-flop synchroniser plus output register. It is reused by future devices.

Test Plan:
- Read 0x7F14, device 1 acks after 2 WAIT cycles with 0xDEADBEEF → pr_stall high 3 cycles, then DONE: pr_rd=0xDEADBEEF, pr_err=0; dev_sel=2'b10 only during WAIT.
- Write 0x7F08 data 0x12345678, device 0 acks in first WAIT → dev_we=2'b01 and dev_wd=0x12345678 for exactly 1 cycle; pr_err=0.
- Unmapped read 0x7F0C and misaligned write 0x7F02 → no dev_sel or dev_we activity, 1 stall cycle, DONE with pr_err=1, pr_rd=0.
- Read 0x7F00 with no ack, TIMEOUT=16 → exactly 16 WAIT cycles, then pr_err=1, pr_rd=0. An ack on the final WAIT cycle instead returns data with pr_err=0.
- dev_irq=2'b01 then ext_int=1 → hw_int becomes 6'b000001 three edges after dev_irq rises, then 6'b000101 three edges after ext_int rises.
- reset=0 asserted mid-WAIT of a write → dev_we and dev_sel drop before the next edge; after release state=IDLE and the write never occurs.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared definitions for the CPU-to-peripheral I/O bridge family:
// FSM encoding, default address map and interrupt vector width.
package io_bus_pkg;

  localparam int unsigned HW_INT_W = 6;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7F00;
  localparam logic [31:0] DEF_STRIDE    = 32'h0000_0010;
  localparam int unsigned DEF_WIN_BYTES = 12;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic [31:0] win_base(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input int unsigned idx);
    return base + stride * idx;
  endfunction

endpackage

// File: rtl/io_bridge_n_if.sv
// CPU-side and device-side bus of the I/O bridge; master is the CPU/device
// environment, slave is the bridge itself.
interface io_bridge_n_if #(
  parameter int unsigned NUM_DEV = 2
);
  logic [31:0]           pr_addr;
  logic                  pr_re;
  logic                  pr_we;
  logic [31:0]           pr_wd;
  logic [31:0]           pr_rd;
  logic                  pr_stall;
  logic                  pr_err;
  logic [31:0]           dev_addr;
  logic [31:0]           dev_wd;
  logic [NUM_DEV-1:0]    dev_sel;
  logic [NUM_DEV-1:0]    dev_we;
  logic [32*NUM_DEV-1:0] dev_rd;
  logic [NUM_DEV-1:0]    dev_ack;

  modport master (
    output pr_addr, pr_re, pr_we, pr_wd, dev_rd, dev_ack,
    input  pr_rd, pr_stall, pr_err, dev_addr, dev_wd, dev_sel, dev_we
  );

  modport slave (
    input  pr_addr, pr_re, pr_we, pr_wd, dev_rd, dev_ack,
    output pr_rd, pr_stall, pr_err, dev_addr, dev_wd, dev_sel, dev_we
  );
endinterface

// File: rtl/io_irq_sync.sv
// N-bit two-flop synchroniser followed by a registered output stage;
// a rising input appears on q three clock edges later.
module io_irq_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      q  <= s2;
    end
  end

endmodule

// File: rtl/io_bridge_n.sv
// CPU I/O bridge: decodes accesses onto NUM_DEV device windows with a
// stall/ack handshake, access timeout, bus errors and synchronised interrupts.
module io_bridge_n
  import io_bus_pkg::*;
#(
  parameter int unsigned NUM_DEV   = 2,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] STRIDE    = DEF_STRIDE,
  parameter int unsigned WIN_BYTES = DEF_WIN_BYTES,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                reset,
  io_bridge_n_if.slave        bus,
  input  logic [NUM_DEV-1:0]  dev_irq,
  input  logic                ext_int,
  output logic [HW_INT_W-1:0] hw_int
);

  if (NUM_DEV < 1 || NUM_DEV > 5) begin : g_bad_num_dev
    $fatal(1, "io_bridge_n: NUM_DEV must be in 1..5");
  end

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [31:0]        addr_q;
  logic [31:0]        wd_q;
  logic [31:0]        rd_q;
  logic               we_q;
  logic               err_q;
  logic [NUM_DEV-1:0] sel_q;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_DEV-1:0] hit;
  logic [NUM_DEV-1:0] ack_hit;
  logic [31:0]        lo;
  logic [31:0]        ack_data;
  logic               req;
  logic               valid;
  logic               timeout_hit;
  logic [NUM_DEV:0]   irq_q;

  // Window i covers [base_i, base_i + WIN_BYTES - 1], compared at full width.
  always_comb begin
    hit = '0;
    lo  = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      lo     = win_base(BASE_ADDR, STRIDE, i);
      hit[i] = (bus.pr_addr >= lo) && (bus.pr_addr <= lo + (WIN_BYTES - 1));
    end
  end

  assign req         = bus.pr_re | bus.pr_we;
  assign valid       = (|hit) && (bus.pr_addr[1:0] == 2'b00);
  assign ack_hit     = bus.dev_ack & sel_q;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    ack_data = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (sel_q[i]) ack_data = ack_data | bus.dev_rd[32*i +: 32];
    end
  end

  // A write wins when pr_re and pr_we are both high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      sel_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (valid) begin
              addr_q <= bus.pr_addr;
              wd_q   <= bus.pr_wd;
              we_q   <= bus.pr_we;
              sel_q  <= hit;
              cnt    <= '0;
              state  <= ST_WAIT;
            end else begin
              err_q <= 1'b1;
              rd_q  <= '0;
              state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (|ack_hit) begin
            rd_q  <= we_q ? '0 : ack_data;
            err_q <= 1'b0;
            state <= ST_DONE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            rd_q  <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pr_stall = ((state == ST_IDLE) && req) || (state == ST_WAIT);
    bus.pr_rd    = rd_q;
    bus.pr_err   = (state == ST_DONE) && err_q;
    bus.dev_sel  = (state == ST_WAIT) ? sel_q : '0;
    bus.dev_we   = ((state == ST_WAIT) && we_q) ? sel_q : '0;
    bus.dev_addr = addr_q;
    bus.dev_wd   = wd_q;
  end

  io_irq_sync #(.WIDTH(NUM_DEV + 1)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({ext_int, dev_irq}),
    .q     (irq_q)
  );

  always_comb begin
    hw_int            = '0;
    hw_int[NUM_DEV:0] = irq_q;
  end

endmodule

// File: tb/tb_io_bridge_n.sv
// Directed bench for io_bridge_n with hand-computed expectations.
module tb_io_bridge_n;
  import io_bus_pkg::*;

  localparam int unsigned NUM_DEV = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NUM_DEV-1:0]  dev_irq;
  logic                ext_int;
  logic [HW_INT_W-1:0] hw_int;

  int errors = 0;
  int checks = 0;

  io_bridge_n_if #(.NUM_DEV(NUM_DEV)) bus ();

  io_bridge_n #(
    .NUM_DEV   (NUM_DEV),
    .BASE_ADDR (32'h0000_7F00),
    .STRIDE    (32'h0000_0010),
    .WIN_BYTES (12),
    .TIMEOUT   (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .dev_irq (dev_irq),
    .ext_int (ext_int),
    .hw_int  (hw_int)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access and acts as the devices: ack_mask is driven on WAIT
  // cycle ack_at (0-based), -1 means never. Returns what the CPU side saw.
  task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                            input logic [1:0] ack_mask, input int ack_at, input logic [31:0] data,
                            output int stalls, output logic [31:0] rd, output logic err,
                            output logic [1:0] sel_seen, output int we_cycles,
                            output logic [31:0] wd_seen);
    int waits;
    bit done;
    waits = 0; done = 0; stalls = 0; rd = '0; err = 1'b0;
    sel_seen = '0; we_cycles = 0; wd_seen = '0;
    bus.pr_addr = addr; bus.pr_we = we; bus.pr_re = !we; bus.pr_wd = wd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      bus.dev_ack = '0;
      #1;
      if (!bus.pr_stall) begin
        done = 1;
        rd   = bus.pr_rd;
        err  = bus.pr_err;
        sel_seen = sel_seen | bus.dev_sel;
        if (bus.dev_we != '0) we_cycles++;
      end else begin
        stalls++;
        sel_seen = sel_seen | bus.dev_sel;
        if (bus.dev_we != '0) begin
          we_cycles++;
          wd_seen = bus.dev_wd;
        end
        if (bus.dev_sel != '0) begin
          if (waits == ack_at) begin
            bus.dev_ack = ack_mask;
            for (int i = 0; i < 2; i++)
              bus.dev_rd[32*i +: 32] = ack_mask[i] ? data : (32'hBAD0_0000 | i);
          end
          waits++;
        end
        tick();
      end
    end
    check("access_bound", 32'(done), 32'd1);
    bus.pr_re = 1'b0; bus.pr_we = 1'b0; bus.dev_ack = '0;
    tick();
  endtask

  int          stalls;
  int          we_cycles;
  logic [31:0] rd;
  logic        err;
  logic [1:0]  sel_seen;
  logic [31:0] wd_seen;

  initial begin
    bus.pr_addr = '0; bus.pr_re = 1'b0; bus.pr_we = 1'b0; bus.pr_wd = '0;
    bus.dev_rd = '0; bus.dev_ack = '0;
    dev_irq = '0; ext_int = 1'b0;

    #12;
    check("rst_stall", 32'(bus.pr_stall), 32'd0);
    check("rst_err", 32'(bus.pr_err), 32'd0);
    check("rst_rd", bus.pr_rd, 32'd0);
    check("rst_sel", 32'(bus.dev_sel), 32'd0);
    check("rst_we", 32'(bus.dev_we), 32'd0);
    check("rst_addr", bus.dev_addr, 32'd0);
    check("rst_hw_int", 32'(hw_int), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Read from device 1, ack on the second WAIT cycle.
    run_access(32'h7F14, 1'b0, 32'h0, 2'b10, 1, 32'hDEAD_BEEF, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("rd_stalls", 32'(stalls), 32'd3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", 32'(err), 32'd0);
    check("rd_sel", 32'(sel_seen), 32'b10);
    check("rd_hold", bus.pr_rd, 32'hDEAD_BEEF);
    check("rd_err_idle", 32'(bus.pr_err), 32'd0);

    // Gap between windows is unmapped.
    run_access(32'h7F0C, 1'b0, 32'h0, 2'b00, -1, 32'h0, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("unmap_stalls", 32'(stalls), 32'd1);
    check("unmap_sel", 32'(sel_seen), 32'd0);
    check("unmap_err", 32'(err), 32'd1);
    check("unmap_rd", rd, 32'd0);

    run_access(32'h7F08, 1'b1, 32'h1234_5678, 2'b01, 0, 32'hFFFF_FFFF, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("wr_stalls", 32'(stalls), 32'd2);
    check("wr_we_cycles", 32'(we_cycles), 32'd1);
    check("wr_wd", wd_seen, 32'h1234_5678);
    check("wr_sel", 32'(sel_seen), 32'b01);
    check("wr_err", 32'(err), 32'd0);
    check("wr_rd", rd, 32'd0);
    check("wr_addr", bus.dev_addr, 32'h7F08);

    run_access(32'h7F02, 1'b1, 32'hAAAA_5555, 2'b00, -1, 32'h0, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("mis_stalls", 32'(stalls), 32'd1);
    check("mis_sel", 32'(sel_seen), 32'd0);
    check("mis_we", 32'(we_cycles), 32'd0);
    check("mis_err", 32'(err), 32'd1);

    run_access(32'h7F1C, 1'b0, 32'h0, 2'b00, -1, 32'h0, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("past_win1_err", 32'(err), 32'd1);

    // No ack: request cycle plus 16 WAIT cycles.
    run_access(32'h7F00, 1'b0, 32'h0, 2'b00, -1, 32'h0, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("to_stalls", 32'(stalls), 32'd17);
    check("to_err", 32'(err), 32'd1);
    check("to_rd", rd, 32'd0);

    run_access(32'h7F04, 1'b0, 32'h0, 2'b01, 15, 32'hCAFE_F00D, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("late_stalls", 32'(stalls), 32'd17);
    check("late_err", 32'(err), 32'd0);
    check("late_rd", rd, 32'hCAFE_F00D);

    // Ack from the wrong device must not complete the access.
    run_access(32'h7F18, 1'b0, 32'h0, 2'b01, 0, 32'h1111_2222, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("wrong_ack_stalls", 32'(stalls), 32'd17);
    check("wrong_ack_err", 32'(err), 32'd1);
    check("wrong_ack_rd", rd, 32'd0);

    dev_irq = 2'b01;
    tick();
    check("irq_edge1", 32'(hw_int), 32'd0);
    tick();
    check("irq_edge2", 32'(hw_int), 32'd0);
    tick();
    check("irq_edge3", 32'(hw_int), 32'b000001);
    ext_int = 1'b1;
    tick();
    tick();
    check("ext_edge2", 32'(hw_int), 32'b000001);
    tick();
    check("ext_edge3", 32'(hw_int), 32'b000101);

    // Reset in the middle of a write's WAIT phase.
    bus.pr_addr = 32'h7F04; bus.pr_wd = 32'hA5A5_A5A5; bus.pr_we = 1'b1; bus.pr_re = 1'b0;
    tick();
    check("rst_wait_we", 32'(bus.dev_we), 32'b01);
    #2;
    reset = 1'b0;
    bus.pr_we = 1'b0;
    #1;
    check("rst_mid_we", 32'(bus.dev_we), 32'd0);
    check("rst_mid_sel", 32'(bus.dev_sel), 32'd0);
    check("rst_mid_stall", 32'(bus.pr_stall), 32'd0);
    check("rst_mid_wd", bus.dev_wd, 32'd0);
    check("rst_mid_hw_int", 32'(hw_int), 32'd0);
    bus.dev_ack = 2'b01;
    @(negedge clk);
    reset = 1'b1;
    we_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.dev_we != '0 || bus.pr_err) we_cycles++;
    end
    check("rst_no_write", 32'(we_cycles), 32'd0);
    bus.dev_ack = '0;

    run_access(32'h7F08, 1'b0, 32'h0, 2'b01, 0, 32'h0BAD_F00D, stalls, rd, err, sel_seen, we_cycles, wd_seen);
    check("post_rst_rd", rd, 32'h0BAD_F00D);
    check("post_rst_stalls", 32'(stalls), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
